weight_load_ctrl: RTL and testbench
===================================

WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: fixed-point word width in bits, matching the network word width.
REQ-002 SHALL have parameter ND, default 8: total node count, equal to the width of the network's per-node shift-enable vector.
REQ-003 SHALL have parameter WPN, default 4: weights per node, bias included.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: begin a full load sequence.
REQ-007 SHALL have port abort, input, 1: cancel the sequence in progress.
REQ-008 SHALL have port s_valid, input, 1: weight stream beat valid.
REQ-009 SHALL have port s_data, input, N: signed weight word.
REQ-010 SHALL have port s_ready, output, 1: controller accepts a beat.
REQ-011 SHALL have port we, output, ND: one-hot per-node shift enable.
REQ-012 SHALL have port bus, output, N: signed weight word to the node shift registers.
REQ-013 SHALL have port busy, output, 1: a sequence is in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.
REQ-015 SHALL have port err, output, 1: one-cycle pulse when start arrives while busy.
REQ-016 SHALL have port chk, output, N: weight checksum (see Configuration).

Function
REQ-017 SHALL implement states IDLE, LOAD and DONE, with node counter nc (0..ND-1) and weight counter wc (0..WPN-1).
REQ-018 IDLE SHALL hold s_ready=0 and we=0; start SHALL clear nc and wc and enter LOAD on the next edge.
REQ-019 LOAD SHALL hold s_ready=1 and busy=1; a beat SHALL be accepted only on s_valid&&s_ready.
REQ-020 Each accepted beat SHALL register bus<=s_data and we<=(1<<nc) with exactly 1-cycle latency, so we is high for exactly one cycle per beat.
REQ-021 In any cycle after no accepted beat, we SHALL be 0 and bus SHALL hold its last value; stalls SHALL NOT cause extra shifts.
REQ-022 On an accepted beat, wc SHALL increment; when wc==WPN-1, wc SHALL wrap to 0 and nc SHALL increment.
REQ-023 On the beat with nc==ND-1 and wc==WPN-1, state SHALL become DONE and s_ready SHALL drop the next cycle; no beat beyond ND*WPN SHALL be accepted.
REQ-024 DONE SHALL assert done for one cycle, coincident with the final we pulse, then return to IDLE.
REQ-025 Total we pulses per completed sequence SHALL be exactly ND*WPN, nodes in order 0..ND-1, WPN consecutive pulses each.
REQ-026 start while busy SHALL be ignored (counters unchanged) and SHALL pulse err for one cycle.
REQ-027 abort in LOAD SHALL win over an accepted beat in the same cycle: that beat is not consumed, we=0 next cycle, no done, and state returns to IDLE.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 start and abort asserted together in IDLE SHALL start a sequence.

Reset
REQ-030 Asserting rst low SHALL asynchronously force IDLE, nc=wc=0, we=0, bus=0, s_ready=0, busy=0, done=0, err=0 and chk=0, including in the middle of a sequence.
REQ-031 Release of rst SHALL be synchronized internally; no beat SHALL be accepted in the first cycle after release.

Configuration
REQ-032 With macro WLC_CHECKSUM_EN defined, chk SHALL be the modulo-2^N sum of all accepted s_data in the current sequence, cleared on start and valid from the done cycle.
REQ-033 Without WLC_CHECKSUM_EN, chk SHALL be constant 0 and no adder SHALL be synthesized.

Structure
REQ-034 The state encoding and a clog2 function for the counter widths SHALL live in the shared fixed-point/network package header, alongside the word-width definition.
REQ-035 The one-hot decode SHALL be sub-module onehot_dec (parameter ND, input index, output ND-bit vector).

Verification
REQ-036 With ND=3, WPN=2, start, then 6 beats 1..6 back-to-back: we SHALL be 001,001,010,010,100,100 with bus 1..6, done coincident with the 6th pulse, and chk=21 when WLC_CHECKSUM_EN is defined.
REQ-037 Same configuration with s_valid toggled 1,0,1,0: we SHALL pulse only the cycle after each accepted beat, and we=0 in gap cycles.
REQ-038 Start, 3 beats, then abort with s_valid=1: no 4th we pulse, busy=0 next cycle, done never asserted; a new start SHALL begin again at node 0.
REQ-039 start pulsed during LOAD after beat 2: err=1 for one cycle and the sequence completes normally with 6 pulses.
REQ-040 rst low after beat 4, released, start, 6 beats: outputs reset immediately, and the full 001..100 pattern repeats.
REQ-041 s_valid held 1 after the final beat: s_ready=0 and no 7th we pulse.

Source files
------------

// File: rtl/weight_load_ctrl_pkg.sv
// rtl/weight_load_ctrl_pkg.sv - shared fixed-point/network definitions for the weight loader
//   WORD_W  : network fixed-point word width
//   state_t : weight loader FSM encoding (IDLE, LOAD, DONE)
//   clog2   : counter width helper, never returns less than 1
package weight_load_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/weight_load_ctrl_onehot_dec.sv
// rtl/weight_load_ctrl_onehot_dec.sv - binary index to one-hot node enable decoder
//   ND     : number of outputs
//   index  : binary node index (indices >= ND decode to all zeros)
//   onehot : ND-bit one-hot vector
module onehot_dec
  import weight_load_ctrl_pkg::*;
#(
  parameter int ND = 8
) (
  input  logic [clog2(ND)-1:0] index,
  output logic [ND-1:0]        onehot
);

  localparam int IW = clog2(ND);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < ND; i++) begin
      onehot[i] = (index == IW'(i));
    end
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - streams ND*WPN weights into per-node shift registers
//   Optional feature macro: WLC_CHECKSUM_EN (drives chk with the running weight sum)
//   clk, rst (async active-low)      : clock and reset
//   start, abort                     : sequence control
//   s_valid, s_data, s_ready         : incoming weight stream
//   we, bus                          : registered one-hot shift enable and weight word
//   busy, done, err                  : status (done/err are one-cycle pulses)
//   chk                              : weight checksum, 0 when the feature is disabled
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int N   = WORD_W,
  parameter int ND  = 8,
  parameter int WPN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [N-1:0]  s_data,
  output logic          s_ready,
  output logic [ND-1:0] we,
  output logic [N-1:0]  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [N-1:0]  chk
);

  localparam int NCW = clog2(ND);
  localparam int WCW = clog2(WPN);

  // Reset release is retimed through two flops; until it propagates the FSM
  // refuses start, so no beat can be taken in the first cycles after release.
  logic [1:0] rst_sync;
  logic       run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  state_t         state, state_nx;
  logic [NCW-1:0] nc;
  logic [WCW-1:0] wc;
  logic           accept;
  logic           start_ok;
  logic           err_nx;
  logic           wc_last;
  logic           last_beat;
  logic [ND-1:0]  node_sel;

  assign wc_last   = (wc == WCW'(WPN - 1));
  assign last_beat = wc_last && (nc == NCW'(ND - 1));

  onehot_dec #(.ND(ND)) u_dec (
    .index  (nc),
    .onehot (node_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Abort takes priority over a beat offered in the same cycle, so that beat
  // is never consumed. start outside IDLE only raises err.
  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    start_ok = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start && run) begin
          state_nx = LOAD;
          start_ok = 1'b1;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        err_nx  = start;
        if (abort) begin
          state_nx = IDLE;
        end else if (s_valid) begin
          accept = 1'b1;
          if (last_beat) state_nx = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        err_nx   = start;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nc <= '0;
      wc <= '0;
    end else if (start_ok) begin
      nc <= '0;
      wc <= '0;
    end else if (accept) begin
      if (wc_last) begin
        wc <= '0;
        nc <= nc + 1'b1;
      end else begin
        wc <= wc + 1'b1;
      end
    end
  end

  // we is a one-cycle pulse per accepted beat; bus holds its last word during stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we   <= '0;
      bus  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      we   <= accept ? node_sel : '0;
      done <= accept && last_beat;
      err  <= err_nx;
      if (accept) bus <= s_data;
    end
  end

`ifdef WLC_CHECKSUM_EN
  logic [N-1:0] chk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          chk_q <= '0;
    else if (start_ok) chk_q <= '0;
    else if (accept)   chk_q <= chk_q + s_data;
  end

  assign chk = chk_q;
`else
  assign chk = '0;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - directed self-checking bench for weight_load_ctrl (ND=3, WPN=2)
module tb_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [2:0]  we;
  logic [15:0] bus;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] chk;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef WLC_CHECKSUM_EN
  localparam logic [15:0] CHK_EXP = 16'd21;
`else
  localparam logic [15:0] CHK_EXP = 16'd0;
`endif

  always #5 clk = ~clk;

  weight_load_ctrl #(.N(16), .ND(3), .WPN(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .we      (we),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .chk     (chk)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs (from a negedge) and return at the next negedge.
  task automatic cyc(input logic st, input logic ab, input logic v, input logic [15:0] d);
    start   = st;
    abort   = ab;
    s_valid = v;
    s_data  = d;
    @(negedge clk);
  endtask

  // Six beats 1..6 after the cycle in which start was taken; optional idle gap after each beat.
  task automatic full_seq(input string tag, input bit gaps);
    logic [2:0] exp_we;
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'(k));
      exp_we = 3'b001 << ((k - 1) / 2);
      check({tag, "_we"}, 32'(we), 32'(exp_we));
      check({tag, "_bus"}, 32'(bus), k);
      check({tag, "_done"}, 32'(done), (k == 6) ? 1 : 0);
      if (gaps && k < 6) begin
        cyc(1'b0, 1'b0, 1'b0, 16'hdead);
        check({tag, "_gap_we"}, 32'(we), 0);
        check({tag, "_gap_bus"}, 32'(bus), k);
      end
    end
    check({tag, "_chk"}, 32'(chk), 32'(CHK_EXP));
    check({tag, "_ready_drop"}, 32'(s_ready), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(we), 0);
    check("rst_bus", 32'(bus), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_chk", 32'(chk), 0);

    // Release with start asserted: the synchronized release must block it.
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 16'h0055);
    check("rel_busy", 32'(busy), 0);
    check("rel_we", 32'(we), 0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Back-to-back beats, s_valid left high after the final beat.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    check("t1_busy", 32'(busy), 1);
    check("t1_ready", 32'(s_ready), 1);
    check("t1_we0", 32'(we), 0);
    full_seq("t1", 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'd7);
    check("t1_no7_we", 32'(we), 0);
    check("t1_no7_done", 32'(done), 0);
    check("t1_no7_bus", 32'(bus), 6);
    check("t1_idle_busy", 32'(busy), 0);
    cyc(1'b0, 1'b0, 1'b1, 16'd8);
    check("t1_idle_we", 32'(we), 0);

    // Toggled s_valid.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    full_seq("t2", 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Abort after three beats with a beat offered.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'd2);
    cyc(1'b0, 1'b0, 1'b1, 16'd3);
    check("t3_we3", 32'(we), 3'b010);
    cyc(1'b0, 1'b1, 1'b1, 16'd99);
    check("t3_abort_we", 32'(we), 0);
    check("t3_abort_busy", 32'(busy), 0);
    check("t3_abort_done", 32'(done), 0);
    check("t3_abort_bus", 32'(bus), 3);
    cyc(1'b0, 1'b1, 1'b1, 16'd98);
    check("t3_idle_abort_busy", 32'(busy), 0);
    check("t3_idle_abort_we", 32'(we), 0);
    // start together with abort in IDLE starts a fresh sequence at node 0.
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    check("t3_restart_busy", 32'(busy), 1);
    full_seq("t3r", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // start during LOAD after beat 2.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'd2);
    check("t4_err_pre", 32'(err), 0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    check("t4_err", 32'(err), 1);
    check("t4_err_we", 32'(we), 0);
    for (int k = 3; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'(k));
      check("t4_we", 32'(we), 32'(3'b001 << ((k - 1) / 2)));
      check("t4_err_clr", 32'(err), 0);
      check("t4_done", 32'(done), (k == 6) ? 1 : 0);
    end
    check("t4_chk", 32'(chk), 32'(CHK_EXP));
    cyc(1'b0, 1'b0, 1'b0, 16'h0);

    // Reset in the middle of a sequence.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b0, 1'b1, 16'(k));
    check("t5_pre_we", 32'(we), 3'b010);
    rst = 1'b0;
    #1;
    check("t5_rst_we", 32'(we), 0);
    check("t5_rst_bus", 32'(bus), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_ready", 32'(s_ready), 0);
    check("t5_rst_chk", 32'(chk), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    check("t5_busy", 32'(busy), 1);
    full_seq("t5", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    check("t5_end_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
